// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI register-write link.
// Holds the frame width, peripheral register map, controller state
// encoding and a width helper. Imported by the controller, the
// peripheral and the bench.
package spi_pkg;

    localparam int SPI_FRAME_W = 16;

    // Peripheral register map (7-bit address field of the frame)
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_e;

    // Bits needed to hold values 0..max_val (at least 1)
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: down-counter used for every timed phase.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load            reload counter with load_val this cycle
//   load_val        value loaded (phase length - 1)
//   expire          high while the count is zero (last cycle of a phase)
module spi_half_period_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode 0 write-only initiator for 16-bit
// {rw, addr[6:0], data[7:0]} frames, MSB first.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (one frame at a time)
//   req_rw, req_addr, req_data  frame fields, sampled on accept only
//   busy                        frame or inter-frame gap in progress
//   done                        one-cycle pulse in the cycle ncs rises
//   sclk, copi, ncs             SPI lines, all straight from flops
module spi_controller
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    // The peripheral resynchronises SCLK/nCS with a 2-FF sync plus edge
    // detect, so shorter half-periods would be missed.
    if (HALF_PERIOD < 3) begin : g_bad_half_period
        $error("spi_controller: HALF_PERIOD must be >= 3");
    end
    if (GAP_CYCLES < 3) begin : g_bad_gap
        $error("spi_controller: GAP_CYCLES must be >= 3");
    end

    localparam int TMR_W = cnt_width((HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES);
    localparam logic [TMR_W-1:0] HP_LOAD  = TMR_W'(HALF_PERIOD - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

    spi_state_e             state_q, state_d;
    logic [SPI_FRAME_W-1:0] shreg_q, shreg_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic                   sclk_q, sclk_d;
    logic                   ncs_q, ncs_d;
    logic                   done_q, done_d;
    logic                   tmr_load;
    logic [TMR_W-1:0]       tmr_val;
    logic                   tmr_expire;

    spi_half_period_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    // copi is the shift register MSB: the register is cleared whenever
    // the line must idle low, so no separate copi flop is needed.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        ncs_d     = ncs_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = HP_LOAD;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    shreg_d   = {req_rw, req_addr, req_data};
                    bit_cnt_d = '0;
                    ncs_d     = 1'b0;
                    sclk_d    = 1'b0;
                    tmr_load  = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tmr_expire) begin
                    sclk_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = HIGH;
                end
            end
            HIGH: begin
                if (tmr_expire) begin
                    sclk_d   = 1'b0;
                    tmr_load = 1'b1;
                    if (bit_cnt_q == 5'd15) begin
                        state_d = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        shreg_d   = {shreg_q[SPI_FRAME_W-2:0], 1'b0};
                        state_d   = LOW;
                    end
                end
            end
            LOW: begin
                if (tmr_expire) begin
                    sclk_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = HIGH;
                end
            end
            HOLD: begin
                // bit 0 stays on copi for a full half-period after the
                // last rising edge, then the frame closes
                if (tmr_expire) begin
                    ncs_d    = 1'b1;
                    shreg_d  = '0;
                    done_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (tmr_expire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            done_q    <= done_d;
        end
    end

    assign sclk = sclk_q;
    assign copi = shreg_q[SPI_FRAME_W-1];
    assign ncs  = ncs_q;
    assign done = done_q;

endmodule
